// File: rtl/clk_rst_sequencer_pkg.sv
// Shared types and default 27 MHz timing for the clock/reset/camera power-up sequencer.
package clk_rst_sequencer_pkg;

    localparam int unsigned CNT_W   = 20;
    localparam int unsigned RETRY_W = 3;

    localparam int unsigned DEF_PLL_RST_CYC      = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 65536;
    localparam int unsigned DEF_LOCK_STABLE_CYC  = 1024;
    localparam int unsigned DEF_PWDN_CYC         = 27000;
    localparam int unsigned DEF_CAMRST_CYC       = 27000;
    localparam int unsigned DEF_CAM_WAIT_CYC     = 540000;
    localparam int unsigned DEF_MAX_RETRY        = 7;

    typedef enum logic [3:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_PWDN,
        ST_CAMRST,
        ST_CAMWAIT,
        ST_CFG,
        ST_RUN,
        ST_FAULT
    } state_t;

    typedef struct packed {
        logic pll_reset;
        logic sys_rst;
        logic cam_pwdn;
        logic cam_rst_n;
    } pins_t;

    // Static pin levels per state; camera held powered down and in reset until PWDN completes.
    function automatic pins_t state_pins(input state_t s);
        pins_t p;
        p.pll_reset = 1'b0;
        p.sys_rst   = 1'b1;
        p.cam_pwdn  = 1'b1;
        p.cam_rst_n = 1'b0;
        case (s)
            ST_PLL_RST: p.pll_reset = 1'b1;
            ST_CAMRST:  p.cam_pwdn  = 1'b0;
            ST_CAMWAIT, ST_CFG, ST_RUN: begin
                p.sys_rst   = 1'b0;
                p.cam_pwdn  = 1'b0;
                p.cam_rst_n = 1'b1;
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_rst_sequencer.sv
// PLL reset/lock supervision followed by camera power-up, SCCB config handshake and run/fault.
module clk_rst_sequencer
    import clk_rst_sequencer_pkg::*;
#(
    parameter int unsigned PLL_RST_CYC      = DEF_PLL_RST_CYC,
    parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int unsigned PWDN_CYC         = DEF_PWDN_CYC,
    parameter int unsigned CAMRST_CYC       = DEF_CAMRST_CYC,
    parameter int unsigned CAM_WAIT_CYC     = DEF_CAM_WAIT_CYC,
    parameter int unsigned MAX_RETRY        = DEF_MAX_RETRY
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_lock,
    input  logic               cfg_done,
    input  logic               cfg_err,
    output logic               pll_reset,
    output logic               sys_rst,
    output logic               cam_pwdn,
    output logic               cam_rst_n,
    output logic               cfg_start,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt
);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic [RETRY_W-1:0] retry_inc;
    logic               lock_s;
    logic               cnt_last;
    logic               lock_lost;
    pins_t              pins_nxt;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // A state loaded with N leaves on the cycle the counter reads 1, i.e. after N cycles.
    assign cnt_last  = (cnt <= CNT_W'(1));
    assign retry_inc = (retry_cnt >= RETRY_W'(MAX_RETRY)) ? retry_cnt : retry_cnt + RETRY_W'(1);
    assign lock_lost = !lock_s && (state inside {ST_PWDN, ST_CAMRST, ST_CAMWAIT, ST_CFG, ST_RUN});
    assign pins_nxt  = state_pins(state_nxt);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_last ? cnt : cnt - CNT_W'(1);
        retry_nxt = retry_cnt;
        case (state)
            ST_PLL_RST: begin
                if (cnt_last) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = CNT_W'(LOCK_TIMEOUT_CYC);
                end
            end
            ST_WAIT_LOCK: begin
                // The lock cycle seen here already counts toward the stable window.
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = CNT_W'(LOCK_STABLE_CYC) - CNT_W'(1);
                end else if (cnt_last) begin
                    retry_nxt = retry_inc;
                    if (retry_inc >= RETRY_W'(MAX_RETRY)) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        state_nxt = ST_PLL_RST;
                        cnt_nxt   = CNT_W'(PLL_RST_CYC);
                    end
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    cnt_nxt = CNT_W'(LOCK_STABLE_CYC);
                end else if (cnt_last) begin
                    state_nxt = ST_PWDN;
                    cnt_nxt   = CNT_W'(PWDN_CYC);
                end
            end
            ST_PWDN: begin
                if (cnt_last) begin
                    state_nxt = ST_CAMRST;
                    cnt_nxt   = CNT_W'(CAMRST_CYC);
                end
            end
            ST_CAMRST: begin
                if (cnt_last) begin
                    state_nxt = ST_CAMWAIT;
                    cnt_nxt   = CNT_W'(CAM_WAIT_CYC);
                end
            end
            ST_CAMWAIT: begin
                if (cnt_last) begin
                    state_nxt = ST_CFG;
                end
            end
            ST_CFG: begin
                if (cfg_err) begin
                    state_nxt = ST_PWDN;
                    cnt_nxt   = CNT_W'(PWDN_CYC);
                end else if (cfg_done) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN:   ;
            ST_FAULT: ;
            default: begin
                state_nxt = ST_PLL_RST;
                cnt_nxt   = CNT_W'(PLL_RST_CYC);
            end
        endcase
        if (lock_lost) begin
            state_nxt = ST_PLL_RST;
            cnt_nxt   = CNT_W'(PLL_RST_CYC);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_PLL_RST;
            cnt   <= CNT_W'(PLL_RST_CYC);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs decoded from the next state so every pin is a flop aligned with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pll_reset <= 1'b1;
            sys_rst   <= 1'b1;
            cam_pwdn  <= 1'b1;
            cam_rst_n <= 1'b0;
            cfg_start <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
            retry_cnt <= '0;
        end else begin
            pll_reset <= pins_nxt.pll_reset;
            sys_rst   <= pins_nxt.sys_rst;
            cam_pwdn  <= pins_nxt.cam_pwdn;
            cam_rst_n <= pins_nxt.cam_rst_n;
            cfg_start <= (state_nxt == ST_CFG) && (state != ST_CFG);
            ready     <= (state_nxt == ST_RUN);
            fault     <= (state_nxt == ST_FAULT);
            retry_cnt <= retry_nxt;
        end
    end

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed bench for clk_rst_sequencer with shortened timing parameters.
module tb_clk_rst_sequencer;

    typedef struct packed {
        logic       pll_reset;
        logic       sys_rst;
        logic       cam_pwdn;
        logic       cam_rst_n;
        logic       cfg_start;
        logic       ready;
        logic       fault;
        logic [2:0] retry;
    } outs_t;

    typedef struct {
        logic  lock;
        logic  done;
        logic  err;
        int    n;
        outs_t exp;
    } vec_t;

    localparam outs_t O_PLL     = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    localparam outs_t O_WAIT    = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    localparam outs_t O_CAMRST  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    localparam outs_t O_CAMWAIT = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    localparam outs_t O_CFG1    = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    localparam outs_t O_RUN     = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       cfg_done;
    logic       cfg_err;
    logic       pll_reset;
    logic       sys_rst;
    logic       cam_pwdn;
    logic       cam_rst_n;
    logic       cfg_start;
    logic       ready;
    logic       fault;
    logic [2:0] retry_cnt;
    outs_t      act;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    vec_t vecs[12];

    assign act = {pll_reset, sys_rst, cam_pwdn, cam_rst_n, cfg_start, ready, fault, retry_cnt};

    clk_rst_sequencer #(
        .PLL_RST_CYC      (4),
        .LOCK_TIMEOUT_CYC (32),
        .LOCK_STABLE_CYC  (8),
        .PWDN_CYC         (10),
        .CAMRST_CYC       (10),
        .CAM_WAIT_CYC     (20),
        .MAX_RETRY        (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_lock  (pll_lock),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .pll_reset (pll_reset),
        .sys_rst   (sys_rst),
        .cam_pwdn  (cam_pwdn),
        .cam_rst_n (cam_rst_n),
        .cfg_start (cfg_start),
        .ready     (ready),
        .fault     (fault),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
        end
    endtask

    // Reset is released on a falling edge; that sample point is cycle 0.
    task automatic do_reset();
        rst      = 1'b1;
        pll_lock = 1'b0;
        cfg_done = 1'b0;
        cfg_err  = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("reset_values", int'(act), int'(O_PLL));
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_ready(input int budget, input int done_delay, output bit ok, output int starts);
        int due;
        due    = -1;
        ok     = 1'b0;
        starts = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            cfg_done = (i == due);
            step();
            if (cfg_start) begin
                starts++;
                due = i + done_delay - 1;
            end
            if (ready) ok = 1'b1;
        end
        cfg_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit flag;
        int starts;
        int k;
        int n_found;
        int exp_v;

        // Nominal bring-up; lock driven 3 cycles after pll_reset falls, cfg_done 5 after cfg_start.
        vecs[0]  = '{lock: 1'b0, done: 1'b0, err: 1'b0, n: 3,  exp: O_PLL};
        vecs[1]  = '{lock: 1'b0, done: 1'b0, err: 1'b0, n: 4,  exp: O_WAIT};
        vecs[2]  = '{lock: 1'b1, done: 1'b0, err: 1'b0, n: 19, exp: O_WAIT};
        vecs[3]  = '{lock: 1'b1, done: 1'b0, err: 1'b0, n: 10, exp: O_CAMRST};
        vecs[4]  = '{lock: 1'b1, done: 1'b0, err: 1'b0, n: 20, exp: O_CAMWAIT};
        vecs[5]  = '{lock: 1'b1, done: 1'b0, err: 1'b0, n: 1,  exp: O_CFG1};
        vecs[6]  = '{lock: 1'b1, done: 1'b0, err: 1'b0, n: 4,  exp: O_CAMWAIT};
        vecs[7]  = '{lock: 1'b1, done: 1'b1, err: 1'b0, n: 1,  exp: O_RUN};
        vecs[8]  = '{lock: 1'b1, done: 1'b0, err: 1'b0, n: 3,  exp: O_RUN};
        vecs[9]  = '{lock: 1'b1, done: 1'b1, err: 1'b1, n: 1,  exp: O_RUN};
        vecs[10] = '{lock: 1'b1, done: 1'b0, err: 1'b1, n: 1,  exp: O_RUN};
        vecs[11] = '{lock: 1'b1, done: 1'b0, err: 1'b0, n: 2,  exp: O_RUN};

        do_reset();
        for (int v = 0; v < 12; v++) begin
            for (int j = 0; j < vecs[v].n; j++) begin
                pll_lock = vecs[v].lock;
                cfg_done = vecs[v].done;
                cfg_err  = vecs[v].err;
                step();
                check($sformatf("nominal_vec%0d_%0d", v, j), int'(act), int'(vecs[v].exp));
            end
        end
        cfg_done = 1'b0;
        cfg_err  = 1'b0;

        // Lock chatter in STABLE: PWDN must start 8 cycles after the final lock_s rise.
        do_reset();
        repeat (6) step();
        pll_lock = 1'b1;
        flag     = 1'b0;
        for (int t = 0; t < 4; t++) begin
            repeat (5) begin
                step();
                if (pll_reset) flag = 1'b1;
            end
            pll_lock = 1'b0;
            repeat (5) begin
                step();
                if (pll_reset) flag = 1'b1;
            end
            pll_lock = 1'b1;
        end
        k = cyc;
        check("chatter_no_pll_reset", int'(flag), 0);
        while (cyc < k + 19) step();
        check("chatter_pwdn_still_high", int'(cam_pwdn), 1);
        check("chatter_sys_rst", int'(sys_rst), 1);
        step();
        check("chatter_camrst_entry", int'(cam_pwdn), 0);

        // No lock: three 4-cycle pll_reset pulses 36 cycles apart, then FAULT.
        do_reset();
        for (int c = 0; c <= 120; c++) begin
            if (c > 0) step();
            exp_v = ((c < 108 && (c % 36) < 4) ? 16 : 0) | ((c >= 108) ? 8 : 0)
                  | ((c < 108) ? (c / 36) : 3);
            check("nolock_pr_fault_retry", int'({pll_reset, fault, retry_cnt}), exp_v);
        end
        check("fault_sys_rst", int'(sys_rst), 1);
        check("fault_cam_pwdn", int'(cam_pwdn), 1);
        check("fault_ready", int'(ready), 0);
        pll_lock = 1'b1;
        repeat (20) step();
        check("fault_terminal", int'({fault, pll_reset, ready}), 4);

        // One timeout, then lock; a 1-cycle lock drop in RUN restarts the sequence.
        do_reset();
        repeat (40) step();
        check("retry_after_timeout", int'(retry_cnt), 1);
        pll_lock = 1'b1;
        wait_ready(200, 5, ok, starts);
        check("loss_first_ready", int'(ok), 1);
        check("run_keeps_retry", int'(retry_cnt), 1);
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        step();
        check("loss_not_yet", int'({pll_reset, ready}), 1);
        step();
        check("loss_pll_reset", int'(pll_reset), 1);
        check("loss_ready", int'(ready), 0);
        check("loss_sys_rst_pwdn", int'({sys_rst, cam_pwdn}), 3);
        check("loss_retry", int'(retry_cnt), 1);
        wait_ready(200, 5, ok, starts);
        check("loss_second_ready", int'(ok), 1);
        check("loss_one_cfg_start", starts, 1);
        check("loss_retry_final", int'(retry_cnt), 1);

        // cfg_err with cfg_done together: camera re-power, second cfg_start after 41 cycles.
        do_reset();
        pll_lock = 1'b1;
        flag     = 1'b0;
        for (int i = 0; i < 120 && !flag; i++) begin
            step();
            if (cfg_start) flag = 1'b1;
        end
        check("err_first_cfg_start", int'(flag), 1);
        cfg_done = 1'b1;
        cfg_err  = 1'b1;
        step();
        cfg_done = 1'b0;
        cfg_err  = 1'b0;
        check("err_to_pwdn", int'({cam_pwdn, cam_rst_n, sys_rst, ready}), 4'b1010);
        n_found = -1;
        flag    = 1'b0;
        for (int n = 2; n < 60 && n_found < 0; n++) begin
            step();
            if (ready) flag = 1'b1;
            if (cfg_start) n_found = n;
        end
        check("err_second_cfg_start_delay", n_found, 41);
        check("err_ready_stays_low", int'(flag), 0);
        cfg_done = 1'b1;
        step();
        cfg_done = 1'b0;
        check("err_lone_done_ready", int'(ready), 1);

        // Asynchronous reset between clock edges in CAMWAIT.
        do_reset();
        pll_lock = 1'b1;
        flag     = 1'b0;
        for (int i = 0; i < 150 && !flag; i++) begin
            step();
            if (!sys_rst) flag = 1'b1;
        end
        check("async_reach_camwait", int'(flag), 1);
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        check("async_reset_values", int'(act), int'(O_PLL));
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) step();
            check("async_pll_reset_width", int'(pll_reset), (c < 4) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
